// File: rtl/sat_state_pkg.sv
// Shared encodings for the SAT engine state list and the decision controller.
package sat_state_pkg;

    localparam logic [1:0] VAL_FREE    = 2'b00;
    localparam logic [1:0] VAL_FALSE   = 2'b01;
    localparam logic [1:0] VAL_TRUE    = 2'b10;
    localparam int         IMPLIED_BIT = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        ISSUE = 2'd2
    } dcd_state_e;

endpackage

// File: rtl/dcd_chunk_pe.sv
// Combinational priority encoder: lowest free variable within one scan chunk.
module dcd_chunk_pe
    import sat_state_pkg::*;
#(
    parameter int SCAN_W = 4,
    parameter int WIDTH  = 3,
    parameter int LOC_W  = (SCAN_W > 1) ? $clog2(SCAN_W) : 1
) (
    input  logic [SCAN_W*WIDTH-1:0] slice_i,
    output logic                    found_o,
    output logic [LOC_W-1:0]        idx_o
);

    // Walk from the top down so the lowest free index is the one left standing.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = SCAN_W - 1; i >= 0; i--) begin
            if (slice_i[i*WIDTH+WIDTH-1 -: 2] == VAL_FREE) begin
                found_o = 1'b1;
                idx_o   = LOC_W'(i);
            end
        end
    end

endmodule

// File: rtl/dcd_scan_ctrl.sv
// Decision controller: scans the value vector chunk by chunk for the lowest
// free variable, offers it to BCP over valid/ready and tracks the decision level.
module dcd_scan_ctrl
    import sat_state_pkg::*;
#(
    parameter int         NUM_VARS  = 16,
    parameter int         WIDTH     = 3,
    parameter int         SCAN_W    = 4,
    parameter int         VAR_W     = 4,
    parameter int         LVL_W     = 5,
    parameter logic [1:0] DEC_VALUE = 2'b01
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic [NUM_VARS*WIDTH-1:0] vars_value_i,
    output logic                      decide_valid_o,
    input  logic                      decide_ready_i,
    output logic [VAR_W-1:0]          decide_var_o,
    output logic [1:0]                decide_value_o,
    output logic [LVL_W-1:0]          decide_level_o,
    output logic                      all_assigned_o,
    output logic                      busy_o,
    input  logic                      bkt_i,
    input  logic [LVL_W-1:0]          bkt_level_i,
    output logic [LVL_W-1:0]          cur_level_o
);

    localparam int NUM_CHUNKS = NUM_VARS / SCAN_W;
    localparam int CHUNK_W    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int LOC_W      = (SCAN_W > 1) ? $clog2(SCAN_W) : 1;

    // Handshake: a decision transfers on a rising edge where decide_valid_o and
    // decide_ready_i are both high and bkt_i is low; valid never drops before that
    // unless a backtrack aborts it, and var/value/level hold steady while valid.

    dcd_state_e           state_q, state_d;
    logic [CHUNK_W-1:0]   chunk_q, chunk_d;
    logic                 valid_q, valid_d;
    logic [VAR_W-1:0]     var_q, var_d;
    logic [1:0]           value_q, value_d;
    logic [LVL_W-1:0]     dlvl_q, dlvl_d;
    logic                 all_q, all_d;
    logic [LVL_W-1:0]     cur_q, cur_d;

    logic [SCAN_W*WIDTH-1:0] slice;
    logic                    pe_found;
    logic [LOC_W-1:0]        pe_idx;

    assign slice = vars_value_i[chunk_q*(SCAN_W*WIDTH) +: SCAN_W*WIDTH];

    dcd_chunk_pe #(
        .SCAN_W (SCAN_W),
        .WIDTH  (WIDTH),
        .LOC_W  (LOC_W)
    ) u_pe (
        .slice_i (slice),
        .found_o (pe_found),
        .idx_o   (pe_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            chunk_q <= '0;
            valid_q <= 1'b0;
            var_q   <= '0;
            value_q <= '0;
            dlvl_q  <= '0;
            all_q   <= 1'b0;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            chunk_q <= chunk_d;
            valid_q <= valid_d;
            var_q   <= var_d;
            value_q <= value_d;
            dlvl_q  <= dlvl_d;
            all_q   <= all_d;
            cur_q   <= cur_d;
        end
    end

    always_comb begin
        state_d = state_q;
        chunk_d = chunk_q;
        valid_d = valid_q;
        var_d   = var_q;
        value_d = value_q;
        dlvl_d  = dlvl_q;
        all_d   = 1'b0;
        cur_d   = cur_q;
        // Backtrack overrides start, a pending handshake and the end of a scan.
        if (bkt_i) begin
            state_d = IDLE;
            chunk_d = '0;
            valid_d = 1'b0;
            if (bkt_level_i <= cur_q) begin
                cur_d = bkt_level_i;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d = SCAN;
                        chunk_d = '0;
                    end
                end
                SCAN: begin
                    if (pe_found) begin
                        var_d   = VAR_W'(chunk_q) * VAR_W'(SCAN_W) + VAR_W'(pe_idx);
                        value_d = DEC_VALUE;
                        dlvl_d  = cur_q + LVL_W'(1);
                        valid_d = 1'b1;
                        state_d = ISSUE;
                    end else if (chunk_q == CHUNK_W'(NUM_CHUNKS - 1)) begin
                        all_d   = 1'b1;
                        chunk_d = '0;
                        state_d = IDLE;
                    end else begin
                        chunk_d = chunk_q + CHUNK_W'(1);
                    end
                end
                ISSUE: begin
                    if (decide_ready_i) begin
                        valid_d = 1'b0;
                        cur_d   = cur_q + LVL_W'(1);
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    chunk_d = '0;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    assign decide_valid_o = valid_q;
    assign decide_var_o   = var_q;
    assign decide_value_o = value_q;
    assign decide_level_o = dlvl_q;
    assign all_assigned_o = all_q;
    assign busy_o         = (state_q != IDLE);
    assign cur_level_o    = cur_q;

endmodule

// File: tb/tb_dcd_scan_ctrl.sv
// Self-checking bench for dcd_scan_ctrl: table of decide vectors with a
// scoreboard queue, plus hand-written backtrack/reset/stall sequences.
module tb_dcd_scan_ctrl;

    localparam int NV  = 16;
    localparam int W   = 3;
    localparam int SW  = 4;
    localparam int NCH = NV / SW;

    logic             clk;
    logic             rst;
    logic             start_i;
    logic [NV*W-1:0]  vars_value_i;
    logic             decide_valid_o;
    logic             decide_ready_i;
    logic [3:0]       decide_var_o;
    logic [1:0]       decide_value_o;
    logic [4:0]       decide_level_o;
    logic             all_assigned_o;
    logic             busy_o;
    logic             bkt_i;
    logic [4:0]       bkt_level_i;
    logic [4:0]       cur_level_o;

    dcd_scan_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .vars_value_i   (vars_value_i),
        .decide_valid_o (decide_valid_o),
        .decide_ready_i (decide_ready_i),
        .decide_var_o   (decide_var_o),
        .decide_value_o (decide_value_o),
        .decide_level_o (decide_level_o),
        .all_assigned_o (all_assigned_o),
        .busy_o         (busy_o),
        .bkt_i          (bkt_i),
        .bkt_level_i    (bkt_level_i),
        .cur_level_o    (cur_level_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks    = 0;
    int failures  = 0;
    int hs_count  = 0;
    int model_level = 0;

    // scoreboard entry: {all_assigned, var[3:0], level[4:0]}
    logic [9:0] exp_q[$];

    typedef struct {
        logic [15:0] free_mask;
        logic        exp_aa;
        logic [3:0]  exp_var;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [NV*W-1:0] mk_vars(input logic [15:0] free_mask);
        logic [NV*W-1:0] v;
        v = '0;
        for (int k = 0; k < NV; k++) begin
            if (free_mask[k]) v[k*W +: W] = 3'b000;
            else v[k*W +: W] = {($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01,
                                1'($urandom_range(0, 1))};
        end
        return v;
    endfunction

    // scoreboard monitor: pops on each accepted decision or all-assigned pulse
    always @(negedge clk) begin
        logic [9:0] e;
        if (rst && !bkt_i && ((decide_valid_o && decide_ready_i) || all_assigned_o)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: valid=%0b aa=%0b with empty queue",
                         decide_valid_o, all_assigned_o);
            end else begin
                e = exp_q.pop_front();
                chk("sb_all_assigned", 32'(all_assigned_o), 32'(e[9]));
                chk("sb_exclusive", 32'(decide_valid_o & all_assigned_o), 32'd0);
                if (!e[9]) begin
                    chk("sb_var", 32'(decide_var_o), 32'(e[8:5]));
                    chk("sb_level", 32'(decide_level_o), 32'(e[4:0]));
                    chk("sb_value", 32'(decide_value_o), 32'd1);
                    hs_count++;
                end
            end
        end
    end

    task automatic pulse_start();
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
    endtask

    // Bounded wait from just after the start edge until valid or all_assigned.
    task automatic wait_result(output int n, output logic timed_out);
        n = 0;
        timed_out = 1'b0;
        forever begin
            @(negedge clk);
            if (decide_valid_o || all_assigned_o) break;
            n++;
            if (n > 20) begin
                timed_out = 1'b1;
                break;
            end
        end
        if (timed_out) begin
            checks++;
            failures++;
            $display("FAIL wait_timeout: no valid or all_assigned within 20 cycles");
        end
    endtask

    task automatic decide(input logic [15:0] mask, input logic aa, input logic [3:0] ev);
        int n;
        logic to;
        vars_value_i   = mk_vars(mask);
        decide_ready_i = 1'b1;
        exp_q.push_back({aa, aa ? 4'd0 : ev, aa ? 5'd0 : 5'(model_level + 1)});
        pulse_start();
        wait_result(n, to);
        if (!to) begin
            chk("latency", 32'(n), aa ? 32'(NCH) : 32'(1 + int'(ev) / SW));
            if (aa) begin
                chk("aa_busy_low", 32'(busy_o), 32'd0);
                @(negedge clk);
                chk("aa_one_cycle", 32'(all_assigned_o), 32'd0);
                chk("aa_level_kept", 32'(cur_level_o), 32'(model_level));
            end else begin
                model_level++;
                @(negedge clk);
                chk("valid_dropped", 32'(decide_valid_o), 32'd0);
                chk("level_inc", 32'(cur_level_o), 32'(model_level));
                chk("busy_idle", 32'(busy_o), 32'd0);
            end
        end
    endtask

    initial begin
        int n;
        logic to;
        int hs_before;
        logic aa_seen;
        logic [15:0] m;
        int lo;

        tbl[0] = '{16'h0020, 1'b0, 4'd5};
        tbl[1] = '{16'h0204, 1'b0, 4'd2};
        tbl[2] = '{16'h0200, 1'b0, 4'd9};
        tbl[3] = '{16'h0000, 1'b1, 4'd0};
        tbl[4] = '{16'h8000, 1'b0, 4'd15};
        tbl[5] = '{16'h0001, 1'b0, 4'd0};
        tbl[6] = '{16'h3000, 1'b0, 4'd12};
        tbl[7] = '{16'hFFF0, 1'b0, 4'd4};
        tbl[8] = '{16'h0000, 1'b1, 4'd0};

        rst = 1'b0;
        start_i = 1'b0;
        vars_value_i = '0;
        decide_ready_i = 1'b0;
        bkt_i = 1'b0;
        bkt_level_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_valid", 32'(decide_valid_o), 32'd0);
        chk("rst_var", 32'(decide_var_o), 32'd0);
        chk("rst_value", 32'(decide_value_o), 32'd0);
        chk("rst_level", 32'(decide_level_o), 32'd0);
        chk("rst_aa", 32'(all_assigned_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_cur", 32'(cur_level_o), 32'd0);

        for (int i = 0; i < 9; i++) begin
            decide(tbl[i].free_mask, tbl[i].exp_aa, tbl[i].exp_var);
        end

        for (int r = 0; r < 3; r++) begin
            m = 16'($urandom_range(0, 65535)) & 16'($urandom_range(0, 65535));
            lo = -1;
            for (int k = NV - 1; k >= 0; k--) if (m[k]) lo = k;
            decide(m, (lo < 0), (lo < 0) ? 4'd0 : 4'(lo));
        end

        // stall in ISSUE, then backtrack and ready in the same cycle
        vars_value_i = mk_vars(16'h0020);
        decide_ready_i = 1'b0;
        pulse_start();
        wait_result(n, to);
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", 32'(decide_valid_o), 32'd1);
            chk("stall_var", 32'(decide_var_o), 32'd5);
            chk("stall_value", 32'(decide_value_o), 32'd1);
            chk("stall_level", 32'(decide_level_o), 32'(model_level + 1));
            @(negedge clk);
        end
        @(posedge clk);
        #1 bkt_i = 1'b1;
        bkt_level_i = 5'd0;
        decide_ready_i = 1'b1;
        @(posedge clk);
        #1 bkt_i = 1'b0;
        decide_ready_i = 1'b0;
        @(negedge clk);
        model_level = 0;
        chk("bkt_valid_drop", 32'(decide_valid_o), 32'd0);
        chk("bkt_cur_zero", 32'(cur_level_o), 32'd0);
        chk("bkt_busy", 32'(busy_o), 32'd0);

        // backtrack to a level above current leaves the level alone
        for (int i = 0; i < 3; i++) decide(16'h0001, 1'b0, 4'd0);
        @(posedge clk);
        #1 bkt_i = 1'b1;
        bkt_level_i = 5'd7;
        @(posedge clk);
        #1 bkt_i = 1'b0;
        @(negedge clk);
        chk("bkt_high_keep", 32'(cur_level_o), 32'd3);

        // a second start while scanning must not produce a second decision
        hs_before = hs_count;
        vars_value_i = mk_vars(16'h4000);
        decide_ready_i = 1'b1;
        exp_q.push_back({1'b0, 4'd14, 5'd4});
        pulse_start();
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (12) @(negedge clk);
        model_level = 4;
        chk("start_ignored_hs", 32'(hs_count - hs_before), 32'd1);
        chk("start_ignored_cur", 32'(cur_level_o), 32'd4);

        // backtrack on the final scan chunk suppresses all_assigned
        vars_value_i = mk_vars(16'h0000);
        pulse_start();
        repeat (3) @(posedge clk);
        #1 bkt_i = 1'b1;
        bkt_level_i = 5'd31;
        @(posedge clk);
        #1 bkt_i = 1'b0;
        aa_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (all_assigned_o) aa_seen = 1'b1;
        end
        chk("bkt_suppress_aa", 32'(aa_seen), 32'd0);
        chk("bkt_suppress_cur", 32'(cur_level_o), 32'd4);

        // reset in the middle of a scan (chunk 2)
        vars_value_i = mk_vars(16'h8000);
        pulse_start();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        model_level = 0;
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_valid", 32'(decide_valid_o), 32'd0);
        chk("mid_rst_aa", 32'(all_assigned_o), 32'd0);
        chk("mid_rst_cur", 32'(cur_level_o), 32'd0);
        chk("mid_rst_var", 32'(decide_var_o), 32'd0);
        chk("mid_rst_value", 32'(decide_value_o), 32'd0);
        chk("mid_rst_level", 32'(decide_level_o), 32'd0);
        decide(16'h8000, 1'b0, 4'd15);

        repeat (2) @(negedge clk);
        chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
